// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types for the RV32I memory-port arbiter.
//   XLEN_DEFAULT : default data/address width
//   arb_state_e  : arbiter sequencer states (IDLE/ISSUE/WAIT)
//   owner_e      : which core interface owns the in-flight transaction
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/riscv_arb_starve_guard.sv
// ---------------------------------------------------------------------------
// riscv_arb_starve_guard
// Counts consecutive data grants made while fetch was also waiting. Once the
// count reaches STARVE_MAX, force_fetch tells the arbiter to hand the next
// contested slot to fetch. Only instantiated when RISCV_ARB_STARVE_GUARD_EN
// is defined.
// Ports:
//   clk, rst     : clock, async active-high reset
//   d_grant      : data side granted this cycle
//   if_pending   : fetch request valid this cycle
//   if_grant     : fetch side granted this cycle
//   force_fetch  : next arbitration with fetch pending must pick fetch
// ---------------------------------------------------------------------------
module riscv_arb_starve_guard #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_grant,
  input  logic if_pending,
  input  logic if_grant,
  output logic force_fetch
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (if_grant) begin
      cnt <= '0;
    end else if (d_grant && if_pending && (cnt != CNT_MAX)) begin
      // saturating: at CNT_MAX a pending fetch always wins, so this is belt-and-braces
      cnt <= cnt + CW'(1);
    end
  end

  assign force_fetch = (cnt == CNT_MAX);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter
// Shares one single-ported memory/bus between the RV32I instruction-fetch and
// load/store interfaces. One outstanding transaction; data has priority over
// fetch; a WAIT-state timeout returns an error response to the owner.
// Optional macro RISCV_ARB_STARVE_GUARD_EN enables the fetch anti-starvation
// guard (riscv_arb_starve_guard).
//
//   state | meaning
//   IDLE  | no transaction; grant a requester (req_ready) and latch its fields
//   ISSUE | mem_req_valid held with latched fields until mem_req_ready
//   WAIT  | waiting for mem_rsp_valid or timeout; then respond to owner
//
// Ports:
//   clk, rst                        : clock, async active-high reset
//   if_req_* / if_rsp_*             : fetch request / response (reads only)
//   d_req_* / d_rsp_*               : load/store request / response
//   mem_req_* / mem_rsp_*           : shared bus request / response
//   busy                            : transaction in progress (state != IDLE)
// ---------------------------------------------------------------------------
module riscv_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_req_ready,
  output logic            if_rsp_valid,
  output logic [XLEN-1:0] if_rsp_data,
  output logic            if_rsp_err,
  input  logic            d_req_valid,
  input  logic            d_req_we,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic [XLEN-1:0] d_req_wdata,
  output logic            d_req_ready,
  output logic            d_rsp_valid,
  output logic [XLEN-1:0] d_rsp_rdata,
  output logic            d_rsp_err,
  output logic            mem_req_valid,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  output logic            busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT);

  arb_state_e      state;
  owner_e          owner;
  logic            lat_we;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [TW-1:0]   tmr;

  logic force_fetch;
  logic grant_d;
  logic grant_if;

  always_comb begin
    grant_d  = d_req_valid && !(force_fetch && if_req_valid);
    grant_if = if_req_valid && !grant_d;
  end

  // Ready is gated by rst so no grant leaks out while reset is held.
  assign d_req_ready  = !rst && (state == IDLE) && grant_d;
  assign if_req_ready = !rst && (state == IDLE) && grant_if;

  assign mem_req_valid = (state == ISSUE);
  assign mem_req_we    = lat_we;
  assign mem_req_addr  = lat_addr;
  assign mem_req_wdata = lat_wdata;
  assign busy          = (state != IDLE);

`ifdef RISCV_ARB_STARVE_GUARD_EN
  riscv_arb_starve_guard #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_guard (
    .clk         (clk),
    .rst         (rst),
    .d_grant     (d_req_ready),
    .if_pending  (if_req_valid),
    .if_grant    (if_req_ready),
    .force_fetch (force_fetch)
  );
`else
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign force_fetch       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWNER_IF;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      tmr          <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_err   <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rsp_rdata  <= '0;
      d_rsp_err    <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner     <= OWNER_D;
            lat_we    <= d_req_we;
            lat_addr  <= d_req_addr;
            lat_wdata <= d_req_wdata;
            state     <= ISSUE;
          end else if (grant_if) begin
            owner     <= OWNER_IF;
            lat_we    <= 1'b0;
            lat_addr  <= if_req_addr;
            lat_wdata <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            tmr   <= TMR_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving on the terminal-count cycle still wins over the error.
          if (mem_rsp_valid || (tmr == '0)) begin
            state <= IDLE;
            if (owner == OWNER_D) begin
              d_rsp_valid <= 1'b1;
              d_rsp_err   <= !mem_rsp_valid;
              d_rsp_rdata <= (mem_rsp_valid && !lat_we) ? mem_rsp_rdata : '0;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_err   <= !mem_rsp_valid;
              if_rsp_data  <= mem_rsp_valid ? mem_rsp_rdata : '0;
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req_valid;
  logic [XLEN-1:0] if_req_addr;
  logic            if_req_ready;
  logic            if_rsp_valid;
  logic [XLEN-1:0] if_rsp_data;
  logic            if_rsp_err;
  logic            d_req_valid;
  logic            d_req_we;
  logic [XLEN-1:0] d_req_addr;
  logic [XLEN-1:0] d_req_wdata;
  logic            d_req_ready;
  logic            d_rsp_valid;
  logic [XLEN-1:0] d_rsp_rdata;
  logic            d_rsp_err;
  logic            mem_req_valid;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;
  logic            busy;

  riscv_mem_arbiter #(.XLEN(32), .STARVE_MAX(4), .TIMEOUT(255)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_addr   (if_req_addr),
    .if_req_ready  (if_req_ready),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .if_rsp_err    (if_rsp_err),
    .d_req_valid   (d_req_valid),
    .d_req_we      (d_req_we),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_req_ready   (d_req_ready),
    .d_rsp_valid   (d_rsp_valid),
    .d_rsp_rdata   (d_rsp_rdata),
    .d_rsp_err     (d_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic [31:0] if_q[$];
  dreq_t       d_q[$];
  rsp_t        exp_if[$];
  rsp_t        exp_d[$];
  logic [31:0] mem_wr[logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          if_acc = 0, d_acc = 0;
  logic [15:0] grant_bits = '0;
  int          grant_n = 0;
  int          g_if_cyc = 0, g_d_cyc = 0;
  int          if_rsp_cyc = 0, d_rsp_cyc = 0, hs_cyc = 0;
  logic        d_rsp_busy = 0;

  bit          resp_en = 1, mem_silent = 0;
  int          rdy_stall = 0, rsp_stall = 0;
  int          rphase = 0, stall = 0, rstall = 0;
  logic        cur_we = 0;
  logic [31:0] cur_addr = '0;

  logic        stall_prev = 0;
  logic        prev_we = 0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0104: return 32'h00A0_0113;
      32'h0000_2000: return 32'hDEAD_BEEF;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Fetch requester: presents queued addresses, drops valid after acceptance.
  initial begin
    if_req_valid = 0;
    if_req_addr  = '0;
    forever begin
      @(posedge clk); #1;
      if (if_acc) begin
        if_req_valid = 0;
        if_acc = 0;
      end
      if (!rst && !if_req_valid && if_q.size() > 0) begin
        if_req_addr  = if_q.pop_front();
        if_req_valid = 1;
      end
    end
  end

  // Data requester; d_req_we idles high so a fetch that wrongly copies it shows up.
  initial begin
    d_req_valid = 0;
    d_req_we    = 1;
    d_req_addr  = '0;
    d_req_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (d_acc) begin
        d_req_valid = 0;
        d_acc = 0;
      end
      if (!rst && !d_req_valid && d_q.size() > 0) begin
        dreq_t r;
        r = d_q.pop_front();
        d_req_we    = r.we;
        d_req_addr  = r.addr;
        d_req_wdata = r.wdata;
        d_req_valid = 1;
      end
    end
  end

  // Bus responder with configurable ready/response stalls; write acks return junk data.
  initial begin
    mem_req_ready = 0;
    mem_rsp_valid = 0;
    mem_rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        mem_req_ready = 0;
        mem_rsp_valid = 0;
        if (rphase == 0 && mem_req_valid) begin
          stall  = rdy_stall;
          rphase = 1;
        end else if (rphase == 2 && !mem_silent) begin
          if (rstall == 0) begin
            mem_rsp_valid = 1;
            mem_rsp_rdata = cur_we ? 32'hFFFF_FFFF : mem_model(cur_addr);
            rphase = 0;
          end else begin
            rstall--;
          end
        end
        if (rphase == 1) begin
          if (stall == 0) begin
            mem_req_ready = 1;
            cur_we   = mem_req_we;
            cur_addr = mem_req_addr;
            rstall   = rsp_stall;
            rphase   = 2;
          end else begin
            stall--;
          end
        end
      end
    end
  end

  // Monitor / scoreboard: pops expected responses whenever the DUT strobes one.
  initial begin
    forever begin
      @(negedge clk);
      if (if_req_ready || d_req_ready)
        chk("single_grant", 32'(if_req_ready & d_req_ready), 32'd0);
      if (if_req_valid && if_req_ready) begin
        if_acc = 1;
        grant_bits = {grant_bits[14:0], 1'b0};
        grant_n++;
        g_if_cyc = cyc;
      end
      if (d_req_valid && d_req_ready) begin
        d_acc = 1;
        grant_bits = {grant_bits[14:0], 1'b1};
        grant_n++;
        g_d_cyc = cyc;
      end
      if (if_rsp_valid) begin
        if_rsp_cyc = cyc;
        if (exp_if.size() == 0) begin
          chk("if_rsp_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = exp_if.pop_front();
          chk("if_rsp_data", if_rsp_data, e.data);
          chk("if_rsp_err", 32'(if_rsp_err), 32'(e.err));
        end
      end
      if (d_rsp_valid) begin
        d_rsp_cyc  = cyc;
        d_rsp_busy = busy;
        if (exp_d.size() == 0) begin
          chk("d_rsp_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = exp_d.pop_front();
          chk("d_rsp_rdata", d_rsp_rdata, e.data);
          chk("d_rsp_err", 32'(d_rsp_err), 32'(e.err));
        end
      end
      if (mem_req_valid && stall_prev) begin
        chk("mem_we_stable", 32'(mem_req_we), 32'(prev_we));
        chk("mem_addr_stable", mem_req_addr, prev_addr);
        chk("mem_wdata_stable", mem_req_wdata, prev_wdata);
      end
      stall_prev = mem_req_valid && !mem_req_ready && !rst;
      prev_we    = mem_req_we;
      prev_addr  = mem_req_addr;
      prev_wdata = mem_req_wdata;
      if (mem_req_valid && mem_req_ready) begin
        hs_cyc = cyc;
        if (mem_req_we) mem_wr[mem_req_addr] = mem_req_wdata;
      end
    end
  end

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    exp_if.push_back(r);
    if_q.push_back(a);
  endtask

  task automatic push_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] d, input logic e);
    rsp_t  r;
    dreq_t q;
    r.data = d;
    r.err  = e;
    q.we = we;
    q.addr = a;
    q.wdata = wd;
    exp_d.push_back(r);
    d_q.push_back(q);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while ((if_q.size() != 0 || d_q.size() != 0 || exp_if.size() != 0 || exp_d.size() != 0 ||
            if_req_valid || d_req_valid || busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout waited=%0d cycles limit=%0d", name, n, budget);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [7:0] exp_order;
    int rel_cyc;

    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        32'({if_req_ready, if_rsp_valid, if_rsp_err, d_req_ready, d_rsp_valid, d_rsp_err,
             mem_req_valid, mem_req_we, busy}), 32'd0);
    chk("reset_mem_addr", mem_req_addr, 32'd0);
    chk("reset_rsp_data", if_rsp_data | d_rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 0;

    // 1: lone fetch, zero-wait bus, with d_req_we left high
    @(posedge clk);
    push_fetch(32'h100, 32'h0050_0093, 1'b0);
    wait_done(50, "lone_fetch");
    chk("fetch_latency", 32'(if_rsp_cyc - g_if_cyc), 32'd3);

    // 2: simultaneous fetch and load; data first, fetch at the following IDLE
    grant_bits = '0;
    grant_n = 0;
    @(posedge clk);
    push_fetch(32'h104, 32'h00A0_0113, 1'b0);
    push_data(1'b0, 32'h2000, 32'h0, 32'hDEAD_BEEF, 1'b0);
    wait_done(50, "contested");
    chk("contested_grants", 32'(grant_n), 32'd2);
    chk("contested_order", 32'(grant_bits[1:0]), 32'h2);
    chk("contested_regrant", 32'(g_if_cyc - g_d_cyc), 32'd3);

    // 3: store with two ready-stall cycles; write ack data must read back as 0
    rdy_stall = 2;
    @(posedge clk);
    push_data(1'b1, 32'h3000, 32'h1234_5678, 32'h0, 1'b0);
    wait_done(50, "store_stall");
    rdy_stall = 0;
    chk("store_latency", 32'(d_rsp_cyc - g_d_cyc), 32'd5);
    chk("store_written", mem_wr.exists(32'h3000) ? mem_wr[32'h3000] : 32'hBAD0_BAD0, 32'h1234_5678);

    // 4: continuous contention, grant order depends on the guard build
    grant_bits = '0;
    grant_n = 0;
    @(posedge clk);
    for (int i = 0; i < 7; i++)
      push_data(1'b0, 32'h5000 + 32'(4 * i), 32'h0, mem_model(32'h5000 + 32'(4 * i)), 1'b0);
    push_fetch(32'h800, mem_model(32'h800), 1'b0);
    wait_done(200, "starve");
`ifdef RISCV_ARB_STARVE_GUARD_EN
    exp_order = 8'b1111_0111;
`else
    exp_order = 8'b1111_1110;
`endif
    chk("starve_grants", 32'(grant_n), 32'd8);
    chk("starve_order", 32'(grant_bits[7:0]), 32'(exp_order));

    // 5: bus never responds on a load -> error response TIMEOUT+1 after WAIT entry
    mem_silent = 1;
    @(posedge clk);
    push_data(1'b0, 32'h4000, 32'h0, 32'h0, 1'b1);
    wait_done(400, "timeout");
    chk("timeout_latency", 32'(d_rsp_cyc - (hs_cyc + 1)), 32'd256);
    chk("timeout_busy_low", 32'(d_rsp_busy), 32'd0);
    rphase = 0;

    // 6: reset while a fetch sits in WAIT; a late bus ack must produce nothing
    @(posedge clk);
    if_q.push_back(32'h200);
    repeat (8) @(posedge clk);
    #1;
    chk("wait_busy", 32'(busy), 32'd1);
    resp_en = 0;
    #1;
    rst = 1;
    #1;
    chk("midreset_outputs",
        32'({if_req_ready, if_rsp_valid, if_rsp_err, d_req_ready, d_rsp_valid, d_rsp_err,
             mem_req_valid, mem_req_we, busy}), 32'd0);
    chk("midreset_data", if_rsp_data | d_rsp_rdata | mem_req_addr | mem_req_wdata, 32'd0);
    mem_silent = 0;
    rphase = 0;
    mem_req_ready = 0;
    mem_rsp_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    rel_cyc = cyc;
    @(posedge clk); #1;
    mem_rsp_valid = 1;
    mem_rsp_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    repeat (10) @(posedge clk);
    chk("no_rsp_after_reset", 32'(if_rsp_cyc > rel_cyc), 32'd0);
    chk("idle_after_reset", 32'(busy), 32'd0);
    resp_en = 1;

    // 7: recovery transaction after reset
    @(posedge clk);
    push_fetch(32'h104, 32'h00A0_0113, 1'b0);
    wait_done(50, "recovery");
    chk("recovery_latency", 32'(if_rsp_cyc - g_if_cyc), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
